// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg -- shared definitions for the bit-serial subtractor.
//   SERIAL_SUB_WIDTH : default operand/result width
//   state_t          : controller state encoding (IDLE=0, RUN=1)
package serial_sub_pkg;

  localparam int SERIAL_SUB_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if -- start/done handshake and operand/result bus of serial_sub.
//   start, a, b, bin : request and operands (master -> slave)
//   busy, done       : progress and one-cycle completion pulse (slave -> master)
//   d, bout          : registered difference and unsigned borrow-out
//   v                : signed overflow, present only when SERIAL_SUB_OVF_EN is defined
interface serial_sub_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             v;
`endif

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
`ifdef SERIAL_SUB_OVF_EN
    , input v
`endif
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
`ifdef SERIAL_SUB_OVF_EN
    , output v
`endif
  );

endinterface

// File: rtl/serial_sub_fs_df.sv
// fs_df -- 1-bit dataflow full subtractor.
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d, bo     : difference bit, borrow-out
module fs_df (
  output logic d,
  output logic bo,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign d  = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub -- bit-serial subtractor, D = A - B - BIN, one bit per clock, LSB first.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : serial_sub_if.slave (start/a/b/bin in; busy/done/d/bout[/v] out)
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output v.
// A run takes WIDTH cycles after the accepting edge; the controller then spends
// one cycle in IDLE before it can accept again.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state_reg;
  state_t           state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] d_reg;
  logic             borrow_reg;
  logic             bout_reg;
  logic             done_reg;
  logic             bit_d;
  logic             bit_bo;
  logic             last_bit;
  logic             accept;
  logic             run;
  logic [WIDTH-1:0] res_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic             v_reg;
`endif

  fs_df u_fs (
    .d   (bit_d),
    .bo  (bit_bo),
    .a   (a_sh_reg[0]),
    .b   (b_sh_reg[0]),
    .bin (borrow_reg)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));
  // The new difference bit enters at the MSB so that after WIDTH shifts the
  // LSB computed first sits at bit 0.
  assign res_next = {bit_d, res_reg[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so a request during
  // a run is dropped rather than queued.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN:  if (last_bit)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    run      = (state_reg == ST_RUN);
    accept   = (state_reg == ST_IDLE) && bus.start;
    bus.busy = run;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_reg    <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      bout_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      v_reg      <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        a_sh_reg   <= bus.a;
        b_sh_reg   <= bus.b;
        borrow_reg <= bus.bin;
        res_reg    <= '0;
        cnt_reg    <= '0;
`ifdef SERIAL_SUB_OVF_EN
        // Operand registers shift away their MSBs, so keep them aside.
        a_msb_reg  <= bus.a[WIDTH-1];
        b_msb_reg  <= bus.b[WIDTH-1];
`endif
      end else if (run) begin
        a_sh_reg   <= a_sh_reg >> 1;
        b_sh_reg   <= b_sh_reg >> 1;
        borrow_reg <= bit_bo;
        res_reg    <= res_next;
        cnt_reg    <= cnt_reg + 1'b1;
        if (last_bit) begin
          d_reg    <= res_next;
          bout_reg <= bit_bo;
          done_reg <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          // bit_d is the MSB of the difference on the last step.
          v_reg    <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ bit_d);
`endif
        end
      end
    end
  end

  assign bus.done = done_reg;
  assign bus.d    = d_reg;
  assign bus.bout = bout_reg;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.v    = v_reg;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub -- self-checking bench for serial_sub (WIDTH=8).
// A cycle-level reference model computes results with integer arithmetic and
// a countdown of the run length; a negedge process compares every cycle.
// Directed scenarios add literal expectations; a random phase follows.
// Define SERIAL_SUB_OVF_EN to also cover the overflow output.
module tb_serial_sub;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(W)) bus ();

  serial_sub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_diff(int a, int b, int bin);
    return W'(a - b - bin);
  endfunction

  function automatic logic ref_borrow(int a, int b, int bin);
    return (a < b + bin);
  endfunction

  function automatic logic ref_ovf(int a, int b, int bin);
    int sa, sb, sd;
    sa = (a >= 2 ** (W - 1)) ? a - 2 ** W : a;
    sb = (b >= 2 ** (W - 1)) ? b - 2 ** W : b;
    sd = sa - sb - bin;
    return (sd < -(2 ** (W - 1))) || (sd > 2 ** (W - 1) - 1);
  endfunction

  logic         m_busy, m_done, m_bout, m_v, m_pb, m_pv;
  logic [W-1:0] m_d, m_pd;
  int           m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_d <= '0; m_bout <= 1'b0; m_v <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus.start) begin
          m_busy <= 1'b1;
          m_left <= W;
          m_pd   <= ref_diff(int'(bus.a), int'(bus.b), int'(bus.bin));
          m_pb   <= ref_borrow(int'(bus.a), int'(bus.b), int'(bus.bin));
          m_pv   <= ref_ovf(int'(bus.a), int'(bus.b), int'(bus.bin));
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_d    <= m_pd;
        m_bout <= m_pb;
        m_v    <= m_pv;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("done", 32'(bus.done), 32'(m_done));
      check("d",    32'(bus.d),    32'(m_d));
      check("bout", 32'(bus.bout), 32'(m_bout));
`ifdef SERIAL_SUB_OVF_EN
      check("v",    32'(bus.v),    32'(m_v));
`endif
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: checks latency, busy length, d holding its old
  // value until done, and the literal result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] exp_d, input logic exp_bout, input logic exp_v,
                        input string name);
    int lat, busy_n;
    logic [W-1:0] d0;
    bit hold_ok;
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    d0 = bus.d;
    tick();
    bus.start = 1'b0;
    lat = -1; busy_n = 0; hold_ok = 1'b1;
    for (int n = 0; n < W + 4; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
      if (bus.busy) busy_n++;
      if (bus.d !== d0) hold_ok = 1'b0;
    end
    check({name, "_latency"}, 32'(lat), 32'(W));
    check({name, "_busy_cycles"}, 32'(busy_n), 32'(W));
    check({name, "_d_hold"}, 32'(hold_ok), 32'd1);
    check({name, "_d"}, 32'(bus.d), 32'(exp_d));
    check({name, "_bout"}, 32'(bus.bout), 32'(exp_bout));
`ifdef SERIAL_SUB_OVF_EN
    check({name, "_v"}, 32'(bus.v), 32'(exp_v));
`else
    if (exp_v) begin end
`endif
    $display("[TB] op %s: a=0x%02h b=0x%02h bin=%0b -> d=0x%02h bout=%0b lat=%0d",
             name, a, b, bin, bus.d, bus.bout, lat);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dn, last, ndone;
    logic [W-1:0] dsave;

    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_d",    32'(bus.d),    32'd0);
    check("reset_bout", 32'(bus.bout), 32'd0);
    rst = 1'b0;
    tick();

    run_op(8'd100, 8'd37, 1'b0, 8'h3F, 1'b0, 1'b0, "basic");
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "wrap");
    run_op(8'h50, 8'h20, 1'b1, 8'h2F, 1'b0, 1'b0, "bin");
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "ovf");
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "noovf");
    run_op(8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1, 1'b1, "ovf_bin");

    // START during a run with different operands must be ignored.
    bus.a = 8'd100; bus.b = 8'd37; bus.bin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.a = 8'hFF; bus.b = 8'h00; bus.bin = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ndone = 0; dsave = '0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (bus.done) begin ndone++; dsave = bus.d; end
    end
    check("ignore_done_count", 32'(ndone), 32'd1);
    check("ignore_d", 32'(dsave), 32'h3F);
    $display("[TB] ignore-start: dones=%0d d=0x%02h", ndone, dsave);
    tick();

    // Reset four cycles into a run.
    bus.a = 8'h12; bus.b = 8'h34; bus.bin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_d",    32'(bus.d),    32'd0);
    check("midrst_bout", 32'(bus.bout), 32'd0);
    $display("[TB] mid-run reset: busy=%0b d=0x%02h", bus.busy, bus.d);
    run_op(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, "after_rst");

    // START held high: one result every W+1 cycles.
    bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
    tick();
    dn = 0; last = -1;
    for (int n = 0; n < 4 * (W + 1) + 2; n++) begin
      @(negedge clk);
      if (bus.done) begin
        dn++;
        if (last >= 0) check("held_interval", 32'(n - last), 32'(W + 1));
        check("held_d", 32'(bus.d), 32'h0F);
        $display("[TB] held-start done #%0d at cycle %0d d=0x%02h", dn, n, bus.d);
        last = n;
      end
    end
    check("held_done_count", 32'(dn), 32'd4);
    bus.start = 1'b0;
    repeat (W + 3) tick();

    // Random phase: model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      bus.start = ($urandom_range(0, 2) != 0);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.bin   = 1'($urandom);
      tick();
      if (bus.done) $display("[TB] rand cycle %0d: d=0x%02h bout=%0b", i, bus.d, bus.bout);
    end
    rst = 1'b0; bus.start = 1'b0;
    repeat (W + 3) tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
